gfx_rom_scheduler: RTL and testbench



---
 rtl/gfx_sched_pkg.sv | 19 +
 rtl/gfx_rom_scheduler_if.sv | 34 +++
 rtl/gfx_sched_pick.sv | 33 +++
 rtl/gfx_rom_scheduler.sv | 135 +++++++++++++
 tb/tb_gfx_rom_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_sched_pkg.sv
// Shared types for the graphics ROM scheduler: requester ids and FSM states.
package gfx_sched_pkg;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        OWN_BG  = 2'd0,
        OWN_FG  = 2'd1,
        OWN_SPR = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gfx_rom_scheduler_if.sv
// Requester and ROM handshake bundle; master is the scheduler side.
interface gfx_rom_scheduler_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
);
    logic          bg_req;
    logic          fg_req;
    logic          spr_req;
    logic [AW-1:0] bg_addr;
    logic [AW-1:0] fg_addr;
    logic [AW-1:0] spr_addr;
    logic          bg_ack;
    logic          fg_ack;
    logic          spr_ack;
    logic [DW-1:0] rd_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;

    modport master (
        input  bg_req, fg_req, spr_req, bg_addr, fg_addr, spr_addr,
        output bg_ack, fg_ack, spr_ack, rd_data,
        output mem_req, mem_addr,
        input  mem_ack, mem_data
    );

    modport slave (
        output bg_req, fg_req, spr_req, bg_addr, fg_addr, spr_addr,
        input  bg_ack, fg_ack, spr_ack, rd_data,
        input  mem_req, mem_addr,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/gfx_sched_pick.sv
// Combinational winner selection among masked bg/fg/spr requests.
module gfx_sched_pick
    import gfx_sched_pkg::*;
(
    input  logic   [NREQ-1:0] req_m,       // {spr, fg, bg}
    input  logic              ptr_fg,
    input  logic              blank,
    input  logic              starve_hit,
    output logic              gnt_vld_c,
    output owner_e            gnt_owner_c
);

    logic   rr_vld_c;
    owner_e rr_own_c;

    assign rr_vld_c = req_m[0] | req_m[1];
    assign rr_own_c = (req_m[0] && req_m[1]) ? (ptr_fg ? OWN_FG : OWN_BG)
                                             : (req_m[1] ? OWN_FG : OWN_BG);

    // Sprites lead in blanking or when starved; otherwise only fill idle slots
    always_comb begin
        gnt_vld_c   = 1'b0;
        gnt_owner_c = OWN_BG;
        if (req_m[2] && (blank || starve_hit || !rr_vld_c)) begin
            gnt_vld_c   = 1'b1;
            gnt_owner_c = OWN_SPR;
        end else if (rr_vld_c) begin
            gnt_vld_c   = 1'b1;
            gnt_owner_c = rr_own_c;
        end
    end

endmodule

// File: rtl/gfx_rom_scheduler.sv
// Shares one graphics ROM port between bg, fg and sprite fetchers with
// blanking-dependent priority, sprite anti-starvation and line overrun flag.
module gfx_rom_scheduler
    import gfx_sched_pkg::*;
#(
    parameter int unsigned AW     = 18,
    parameter int unsigned DW     = 16,
    parameter int unsigned STARVE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hb,
    input  logic                vb,
    input  logic                frame,
    gfx_rom_scheduler_if.master bus,
    output logic                overrun
);

    state_e            state_q, state_d;
    owner_e            owner_q, gnt_owner_c;
    logic              gnt_vld_c, take_c, ack_evt_c;
    logic              ptr_fg_q, mask_q, hb_q, spr_own_c, blank_c, starve_hit_c;
    logic [NREQ-1:0]   req_c, req_m_c, own_oh_c;
    logic [CNT_W-1:0]  starve_q;
    logic [AW-1:0]     addr_sel_c, mem_addr_q;
    logic [DW-1:0]     rd_data_q;
    logic              mem_req_q, bg_ack_q, fg_ack_q, spr_ack_q;

    assign req_c        = {bus.spr_req, bus.fg_req, bus.bg_req};
    assign own_oh_c     = 3'(1) << owner_q;
    // Just-acked owner is ignored in the IDLE cycle after DONE so it can drop req
    assign req_m_c      = mask_q ? (req_c & ~own_oh_c) : req_c;
    assign blank_c      = hb | vb;
    assign starve_hit_c = (starve_q == CNT_W'(STARVE));
    assign spr_own_c    = (state_q != IDLE) && (owner_q == OWN_SPR);

    gfx_sched_pick u_pick (
        .req_m       (req_m_c),
        .ptr_fg      (ptr_fg_q),
        .blank       (blank_c),
        .starve_hit  (starve_hit_c),
        .gnt_vld_c   (gnt_vld_c),
        .gnt_owner_c (gnt_owner_c)
    );

    always_comb begin
        case (gnt_owner_c)
            OWN_FG:  addr_sel_c = bus.fg_addr;
            OWN_SPR: addr_sel_c = bus.spr_addr;
            default: addr_sel_c = bus.bg_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        take_c    = 1'b0;
        ack_evt_c = 1'b0;
        case (state_q)
            IDLE: if (gnt_vld_c) begin
                state_d = BUSY;
                take_c  = 1'b1;
            end
            BUSY: if (bus.mem_ack) begin
                state_d   = DONE;
                ack_evt_c = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction datapath; acks are high exactly during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            owner_q    <= OWN_BG;
            ptr_fg_q   <= 1'b0;
            mask_q     <= 1'b0;
            rd_data_q  <= '0;
            bg_ack_q   <= 1'b0;
            fg_ack_q   <= 1'b0;
            spr_ack_q  <= 1'b0;
        end else begin
            mask_q    <= (state_q == DONE);
            bg_ack_q  <= ack_evt_c && (owner_q == OWN_BG);
            fg_ack_q  <= ack_evt_c && (owner_q == OWN_FG);
            spr_ack_q <= ack_evt_c && (owner_q == OWN_SPR);
            if (take_c) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= addr_sel_c;
                owner_q    <= gnt_owner_c;
                if (gnt_owner_c != OWN_SPR) ptr_fg_q <= (gnt_owner_c == OWN_BG);
            end else if (ack_evt_c) begin
                mem_req_q <= 1'b0;
                rd_data_q <= bus.mem_data;
            end
        end
    end

    // Sprite wait counter: counts only in active display, saturates at STARVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (take_c && (gnt_owner_c == OWN_SPR)) begin
            starve_q <= '0;
        end else if (!blank_c && bus.spr_req && !spr_own_c && (starve_q < CNT_W'(STARVE))) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q    <= 1'b1;
            overrun <= 1'b0;
        end else begin
            hb_q <= hb;
            if (hb && !hb_q && (bus.bg_req || bus.fg_req)) overrun <= 1'b1;
            else if (frame)                                overrun <= 1'b0;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.bg_ack   = bg_ack_q;
    assign bus.fg_ack   = fg_ack_q;
    assign bus.spr_ack  = spr_ack_q;

endmodule

// File: tb/tb_gfx_rom_scheduler.sv
// Randomized bench for gfx_rom_scheduler against a transaction-level reference model.
`timescale 1ns/1ps
module tb_gfx_rom_scheduler;

    localparam int unsigned AW     = 18;
    localparam int unsigned DW     = 16;
    localparam int STARVE = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hb = 1'b0, vb = 1'b0, frame = 1'b0;
    logic overrun;
    logic [2:0]    req = '0;
    logic [AW-1:0] addr [3];
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_data = '0;

    gfx_rom_scheduler_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.bg_req   = req[0];
    assign bus.fg_req   = req[1];
    assign bus.spr_req  = req[2];
    assign bus.bg_addr  = addr[0];
    assign bus.fg_addr  = addr[1];
    assign bus.spr_addr = addr[2];
    assign bus.mem_ack  = mem_ack;
    assign bus.mem_data = mem_data;

    wire [2:0] ack_w = {bus.spr_ack, bus.fg_ack, bus.bg_ack};

    gfx_rom_scheduler #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hb      (hb),
        .vb      (vb),
        .frame   (frame),
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding ROM transaction, described by
    // whether it is waiting on the ROM and whether its ack is showing now.
    bit            m_waiting_rom, m_ack_now;
    int            m_owner, m_mask, m_wait;
    bit            m_pref_fg, m_prev_hb, m_ovr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rd;
    logic [2:0]    m_ack;

    function automatic void model_reset();
        m_waiting_rom = 0; m_ack_now = 0; m_owner = 0; m_mask = -1; m_wait = 0;
        m_pref_fg = 0; m_prev_hb = 1; m_ovr = 0; m_addr = '0; m_rd = '0; m_ack = '0;
    endfunction

    function automatic int model_pick(bit b, bit f, bit s, bit blank);
        int layer = -1;
        if (b && f)  layer = m_pref_fg ? 1 : 0;
        else if (b)  layer = 0;
        else if (f)  layer = 1;
        if (s && (blank || m_wait == STARVE || layer < 0)) return 2;
        return layer;
    endfunction

    function automatic void model_step();
        bit blank = hb | vb;
        bit spr_owned = (m_waiting_rom || m_ack_now) && (m_owner == 2);
        int next_mask = -1;
        int win = -1;
        logic [2:0] next_ack = '0;
        if (m_ack_now) begin
            m_ack_now = 0;
            next_mask = m_owner;
        end else if (m_waiting_rom) begin
            if (mem_ack) begin
                m_waiting_rom = 0;
                m_ack_now = 1;
                next_ack[m_owner] = 1'b1;
                m_rd = mem_data;
            end
        end else begin
            win = model_pick(req[0] && m_mask != 0, req[1] && m_mask != 1,
                             req[2] && m_mask != 2, blank);
            if (win >= 0) begin
                m_waiting_rom = 1;
                m_owner = win;
                m_addr = addr[win];
                if (win < 2) m_pref_fg = (win == 0);
            end
        end
        if (win == 2) m_wait = 0;
        else if (!blank && req[2] && !spr_owned && m_wait < STARVE) m_wait++;
        if (hb && !m_prev_hb && (req[0] || req[1])) m_ovr = 1;
        else if (frame) m_ovr = 0;
        m_prev_hb = hb;
        m_mask = next_mask;
        m_ack = next_ack;
    endfunction

    // Stimulus knobs
    int p_req = 0, p_rereq = 0, blank_mode = 0, dly_lo = 2, dly_hi = 2;
    int line_ctr = 0, resp_cnt = 0, resp_dly = 2;

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                if (ack_w[i]) begin
                    if ($urandom_range(99, 0) < p_rereq) addr[i] = AW'($urandom);
                    else req[i] = 1'b0;
                end
            end else if ($urandom_range(99, 0) < p_req) begin
                req[i] = 1'b1;
                addr[i] = AW'($urandom);
            end
        end
        mem_ack = 1'b0;
        if (bus.mem_req) begin
            resp_cnt++;
            if (resp_cnt >= resp_dly) begin
                mem_ack = 1'b1; mem_data = DW'($urandom);
                resp_cnt = 0; resp_dly = $urandom_range(dly_hi, dly_lo);
            end
        end else begin
            resp_cnt = 0;
            if ($urandom_range(19, 0) == 0) begin
                mem_ack = 1'b1; mem_data = DW'($urandom);
            end
        end
        frame = ($urandom_range(199, 0) == 0);
        case (blank_mode)
            0: begin hb = 1'b0; vb = 1'b0; end
            2: begin hb = 1'b1; vb = 1'b0; end
            default: begin
                if (line_ctr == 0) begin
                    hb = ~hb;
                    if (hb) begin
                        line_ctr = $urandom_range(12, 6);
                        frame = ($urandom_range(2, 0) == 0);
                    end else begin
                        line_ctr = $urandom_range(60, 20);
                        vb = ($urandom_range(7, 0) == 0);
                    end
                end else begin
                    line_ctr--;
                end
            end
        endcase
    endtask

    task automatic compare_outputs();
        check("mem_req", 32'(bus.mem_req), 32'(m_waiting_rom));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        check("ack", 32'(ack_w), 32'(m_ack));
        check("ack_1hot", 32'($countones(ack_w) <= 1), 32'd1);
        check("rd_data", 32'(bus.rd_data), 32'(m_rd));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic tick();
        drive_inputs();
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_reset_values(input string where);
        check({where, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({where, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({where, "_acks"}, 32'(ack_w), 32'd0);
        check({where, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        check({where, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) addr[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Single bg request at 0x00123, ROM answers on its second mem_req cycle... plus one
        blank_mode = 0; p_req = 0; p_rereq = 0; dly_lo = 3; dly_hi = 3; resp_dly = 3;
        req[0] = 1'b1; addr[0] = AW'(18'h00123);
        repeat (16) tick();

        // bg/fg/spr all held in active display: alternation and sprite starvation
        p_req = 100; p_rereq = 100; dly_lo = 2; dly_hi = 2; resp_dly = 2;
        repeat (200) tick();

        // Drain, then raise all three together during hblank
        p_req = 0; p_rereq = 0;
        repeat (40) tick();
        blank_mode = 2;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; addr[i] = AW'($urandom);
        end
        repeat (24) tick();

        // Randomized lines with blanking, frames and variable ROM latency
        blank_mode = 1; p_req = 30; p_rereq = 50; dly_lo = 2; dly_hi = 5;
        repeat (3000) tick();

        // Reset while a ROM request is outstanding
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = bus.mem_req;
        end
        check("busy_wait", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        req = '0; mem_ack = 1'b0; resp_cnt = 0; resp_dly = 2;
        hb = 1'b0; vb = 1'b0; frame = 1'b0; blank_mode = 0;
        @(negedge clk);
        check_reset_values("held_rst");
        rst_n = 1'b1;

        // Fresh bg request after reset, stray mem_acks still injected in idle
        p_req = 0; p_rereq = 0; dly_lo = 2; dly_hi = 2;
        req[0] = 1'b1; addr[0] = AW'($urandom);
        repeat (16) tick();

        blank_mode = 1; p_req = 40; p_rereq = 60; dly_lo = 2; dly_hi = 4;
        repeat (1500) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
